alu381_nibble_sequencer: RTL and testbench

//  Nibble-serial controller for one external 74381-style 4-bit ALU slice. Runs a WIDTH-bit

---
 rtl/alu381_nibble_sequencer.sv | 136 +++++++++++++
 tb/tb_alu381_nibble_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu381_nibble_sequencer.sv
// Nibble-serial sequencer for a single 74381-style 4-bit ALU slice.
// Feeds A/B one nibble per cycle (LS nibble first), ripples the slice's
// group generate/propagate through a registered carry, and assembles the
// WIDTH-bit result. WIDTH must be a multiple of 4 and at least 8.
module alu381_nibble_sequencer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [2:0]       i_op_s,
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_b,
    input  logic             i_op_cin,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry_out,
    output logic             o_zero,
    output logic [3:0]       o_slice_a,
    output logic [3:0]       o_slice_b,
    output logic [2:0]       o_slice_s,
    output logic             o_slice_cn,
    input  logic [3:0]       i_slice_f,
    input  logic             i_slice_g,
    input  logic             i_slice_p
);

    localparam int unsigned N  = WIDTH / 4;
    localparam int unsigned IW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [N-1:0][3:0]    r_a;
    logic [N-1:0][3:0]    r_b;
    logic [2:0]           r_s;
    logic                 r_carry;
    logic [IW-1:0]        r_idx;
    logic [N-1:0][3:0]    r_result;
    logic                 r_carry_out;
    logic                 r_zero;

    logic                 w_accept;
    logic                 w_last;
    logic                 w_arith;
    logic                 w_carry_next;
    logic [N-1:0][3:0]    w_result_next;

    // A new op is taken whenever the sequencer is not mid-run (IDLE or DONE).
    assign w_accept     = i_start && (r_state != S_RUN);
    assign w_last       = (r_state == S_RUN) && (r_idx == IW'(N - 1));
    assign w_arith      = (r_s == 3'b001) || (r_s == 3'b010) || (r_s == 3'b011);
    assign w_carry_next = i_slice_g | (i_slice_p & r_carry);

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_next = r_state;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_next = S_RUN;
            end
            S_RUN: begin
                o_busy = 1'b1;
                if (w_last) w_state_next = S_DONE;
            end
            S_DONE: begin
                o_done       = 1'b1;
                w_state_next = w_accept ? S_RUN : S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Result with the current slice output merged into the active nibble.
    always_comb begin
        w_result_next        = r_result;
        w_result_next[r_idx] = i_slice_f;
    end

    // Operand latch, nibble counter, carry chain and result assembly.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a         <= '0;
            r_b         <= '0;
            r_s         <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_zero      <= 1'b0;
        end else if (w_accept) begin
            r_a      <= i_op_a;
            r_b      <= i_op_b;
            r_s      <= i_op_s;
            r_carry  <= i_op_cin;
            r_idx    <= '0;
            r_result <= '0;
        end else if (r_state == S_RUN) begin
            r_result <= w_result_next;
            r_carry  <= w_carry_next;
            r_idx    <= w_last ? '0 : r_idx + 1'b1;
            if (w_last) begin
                // Flags are taken from the final nibble's values so they are ready in DONE.
                r_carry_out <= w_arith & w_carry_next;
                r_zero      <= (w_result_next == '0);
            end
        end
    end

    assign o_result    = r_result;
    assign o_carry_out = r_carry_out;
    assign o_zero      = r_zero;
    assign o_slice_a   = r_a[r_idx];
    assign o_slice_b   = r_b[r_idx];
    assign o_slice_s   = r_s;
    assign o_slice_cn  = r_carry;

endmodule

// File: tb/tb_alu381_nibble_sequencer.sv
// Bench for alu381_nibble_sequencer: behavioural 74381 slice, word-level
// reference arithmetic, directed cases followed by random operations.
module tb_alu381_nibble_sequencer;

    localparam int W = 16;
    localparam int N = W / 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [2:0]    op_s;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic          op_cin;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic          carry_out;
    logic          zero;
    logic [3:0]    slice_a;
    logic [3:0]    slice_b;
    logic [2:0]    slice_s;
    logic          slice_cn;
    logic [3:0]    slice_f;
    logic          slice_g;
    logic          slice_p;

    int errors = 0;
    int checks = 0;

    logic [2:0]    m_s;
    logic [W-1:0]  m_a;
    logic [W-1:0]  m_b;
    logic          m_cin;

    always #5 clk = ~clk;

    alu381_nibble_sequencer #(.WIDTH(W)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_op_s      (op_s),
        .i_op_a      (op_a),
        .i_op_b      (op_b),
        .i_op_cin    (op_cin),
        .o_busy      (busy),
        .o_done      (done),
        .o_result    (result),
        .o_carry_out (carry_out),
        .o_zero      (zero),
        .o_slice_a   (slice_a),
        .o_slice_b   (slice_b),
        .o_slice_s   (slice_s),
        .o_slice_cn  (slice_cn),
        .i_slice_f   (slice_f),
        .i_slice_g   (slice_g),
        .i_slice_p   (slice_p)
    );

    // Behavioural 74381 slice: arithmetic ops add X+Y+Cn; G/P describe X+Y alone.
    always_comb begin
        logic [3:0] x;
        logic [3:0] y;
        logic [4:0] s5;
        logic [4:0] sc;
        x = slice_a;
        y = slice_b;
        if (slice_s == 3'b001) begin
            x = slice_b;
            y = ~slice_a;
        end else if (slice_s == 3'b010) begin
            y = ~slice_b;
        end
        s5 = {1'b0, x} + {1'b0, y};
        sc = s5 + {4'b0, slice_cn};
        slice_g = s5[4];
        slice_p = (s5[3:0] == 4'hF);
        case (slice_s)
            3'b000:  slice_f = 4'h0;
            3'b100:  slice_f = slice_a ^ slice_b;
            3'b101:  slice_f = slice_a | slice_b;
            3'b110:  slice_f = slice_a & slice_b;
            3'b111:  slice_f = 4'hF;
            default: slice_f = sc[3:0];
        endcase
    end

    // Whole-word reference: {carry_out, result}.
    function automatic logic [W:0] ref_op(input logic [2:0] s, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic cin);
        logic [W:0] t;
        case (s)
            3'b000:  t = '0;
            3'b001:  t = {1'b0, b} + {1'b0, ~a} + {{W{1'b0}}, cin};
            3'b010:  t = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, cin};
            3'b011:  t = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            3'b100:  t = {1'b0, a ^ b};
            3'b101:  t = {1'b0, a | b};
            3'b110:  t = {1'b0, a & b};
            default: t = {1'b0, {W{1'b1}}};
        endcase
        return t;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive an op at the current negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic [2:0] s, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin);
        op_s = s; op_a = a; op_b = b; op_cin = cin; start = 1'b1;
        m_s = s; m_a = a; m_b = b; m_cin = cin;
        @(negedge clk);
        start = 1'b0;
        op_a = $urandom; op_b = $urandom; op_s = 3'($urandom); op_cin = 1'($urandom);
    endtask

    // Wait for done (sample k = cycles since accept), then check latency and flags.
    task automatic finish_op(input int k0);
        int k;
        logic [W:0] e;
        logic [W-1:0] na;
        k = k0;
        while (done !== 1'b1 && k < 20) begin
            check("busy_run", {31'b0, busy}, 32'd1);
            if (k <= N) begin
                na = m_a >> (4 * (k - 1));
                check("slice_a_nibble", {28'b0, slice_a}, {28'b0, na[3:0]});
                check("slice_s", {29'b0, slice_s}, {29'b0, m_s});
            end
            @(negedge clk);
            k++;
        end
        e = ref_op(m_s, m_a, m_b, m_cin);
        check("latency", k, N + 1);
        check("busy_in_done", {31'b0, busy}, 32'd0);
        check("result", {16'b0, result}, {16'b0, e[W-1:0]});
        check("carry_out", {31'b0, carry_out}, {31'b0, e[W]});
        check("zero", {31'b0, zero}, {31'b0, (e[W-1:0] == '0)});
    endtask

    // One cycle after done: pulse gone, result held.
    task automatic post_done();
        logic [W:0] e;
        e = ref_op(m_s, m_a, m_b, m_cin);
        @(negedge clk);
        check("done_pulse", {31'b0, done}, 32'd0);
        check("idle_busy", {31'b0, busy}, 32'd0);
        check("result_held", {16'b0, result}, {16'b0, e[W-1:0]});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        rst = 1'b1; start = 1'b0; op_s = '0; op_a = '0; op_b = '0; op_cin = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_result", {16'b0, result}, 32'd0);
        check("rst_carry_out", {31'b0, carry_out}, 32'd0);
        check("rst_zero", {31'b0, zero}, 32'd0);
        check("rst_slice", {20'b0, slice_a, slice_b, slice_s, slice_cn}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed arithmetic and logic cases. The latency check expects done in the
        // (N+1)-th cycle after the accept edge, sampled N edges later.
        issue(3'b011, 16'h1234, 16'h0FFF, 1'b0); finish_op(1); post_done();
        check("dir_add", {16'b0, result}, 32'h2233);
        issue(3'b011, 16'hFFFF, 16'h0001, 1'b0); finish_op(1); post_done();
        check("dir_ripple_co", {31'b0, carry_out}, 32'd1);
        issue(3'b010, 16'h0100, 16'h0001, 1'b1); finish_op(1); post_done();
        check("dir_sub1", {16'b0, result}, 32'h00FF);
        issue(3'b010, 16'h0001, 16'h0002, 1'b1); finish_op(1); post_done();
        check("dir_sub2", {16'b0, result}, 32'hFFFF);
        issue(3'b001, 16'h0003, 16'h0010, 1'b1); finish_op(1); post_done();
        issue(3'b100, 16'hA5A5, 16'hFFFF, 1'b0); finish_op(1); post_done();
        check("dir_xor", {16'b0, result}, 32'h5A5A);
        issue(3'b111, 16'h0000, 16'h0000, 1'b1); finish_op(1); post_done();
        issue(3'b000, 16'hFFFF, 16'hFFFF, 1'b1); finish_op(1); post_done();
        check("dir_clr_zero", {31'b0, zero}, 32'd1);

        // start during busy is ignored.
        issue(3'b011, 16'h1234, 16'h0FFF, 1'b0);
        @(negedge clk);
        op_s = 3'b111; op_a = 16'hDEAD; op_b = 16'hBEEF; op_cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finish_op(3);

        // Back-to-back: new op issued in the DONE cycle.
        issue(3'b110, 16'hF0F0, 16'h3C3C, 1'b0); finish_op(1);
        post_done();

        // Reset mid-operation aborts without a done pulse.
        issue(3'b011, 16'h1234, 16'h0FFF, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_result", {16'b0, result}, 32'd0);
        seen = 0;
        repeat (N + 4) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        check("abort_no_done", seen, 0);

        // Random operations, every third one chained straight from DONE.
        for (int i = 0; i < 40; i++) begin
            issue(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
                  1'($urandom_range(0, 1)));
            finish_op(1);
            if (i % 3 != 0) post_done();
        end
        post_done();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
